// File: rtl/mips_multi.sv
// Multi-cycle MIPS core: one shared ALU sequenced by a registered control FSM.
// Define MIPS_MULTI_PERF_EN to build the cycle and retired-instruction counters.
module mips_multi #(
    parameter logic [31:0]              RESET_PC   = 32'h0000_0000,
    parameter int                       IMEM_WORDS = 64,
    parameter int                       DMEM_WORDS = 64,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT  = '0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [3:0]  state,
    output logic        retire,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ZERO
    } alu_op_t;

    state_t      cur, nxt;
    alu_op_t     op;
    logic [31:0] ir, mdr, a, b, alu_out;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [31:0] rom  [IMEM_WORDS];
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext;

    logic        rf_we, dm_we, pc_we;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wd, pc_d;

    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_rom
        assign rom[i] = IMEM_INIT[i*32 +: 32];
    end

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign sext   = {{16{ir[15]}}, ir[15:0]};
    assign state  = cur;

    // Operand selection for the single shared ALU
    always_comb begin
        alu_a = a;
        alu_b = b;
        op    = ALU_ADD;
        unique case (cur)
            FETCH: begin
                alu_a = pc;
                alu_b = 32'd4;
            end
            DECODE: begin
                alu_a = pc;
                alu_b = {sext[29:0], 2'b00};
            end
            MEMADR, ADDIEX: alu_b = sext;
            EXEC: begin
                unique case (funct)
                    6'h20:   op = ALU_ADD;
                    6'h22:   op = ALU_SUB;
                    6'h24:   op = ALU_AND;
                    6'h25:   op = ALU_OR;
                    6'h2A:   op = ALU_SLT;
                    default: op = ALU_ZERO;
                endcase
            end
            BRANCH:  op = ALU_SUB;
            default: ;
        endcase
    end

    always_comb begin
        unique case (op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'h0;
        endcase
    end

    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        rf_we  = 1'b0;
        rf_dst = rt;
        rf_wd  = alu_out;
        dm_we  = 1'b0;
        pc_we  = 1'b0;
        pc_d   = alu_y;
        unique case (cur)
            FETCH: begin
                pc_we = 1'b1;
                nxt   = DECODE;
            end
            DECODE: begin
                unique case (opcode)
                    6'h23, 6'h2B: nxt = MEMADR;
                    6'h00:        nxt = EXEC;
                    6'h04, 6'h05: nxt = BRANCH;
                    6'h02:        nxt = JUMP;
                    6'h08:        nxt = ADDIEX;
                    default: begin
                        nxt    = FETCH;
                        retire = 1'b1;
                    end
                endcase
            end
            MEMADR: nxt = (opcode == 6'h23) ? MEMRD : MEMWR;
            MEMRD:  nxt = MEMWB;
            MEMWB: begin
                rf_we  = 1'b1;
                rf_wd  = mdr;
                retire = 1'b1;
                nxt    = FETCH;
            end
            MEMWR: begin
                dm_we  = 1'b1;
                retire = 1'b1;
                nxt    = FETCH;
            end
            EXEC: nxt = RWB;
            RWB: begin
                rf_we  = 1'b1;
                rf_dst = rd;
                retire = 1'b1;
                nxt    = FETCH;
            end
            BRANCH: begin
                // beq takes on zero difference, bne on nonzero
                pc_we  = (opcode == 6'h04) ? (alu_y == 32'h0)
                                           : (alu_y != 32'h0);
                pc_d   = alu_out;
                retire = 1'b1;
                nxt    = FETCH;
            end
            JUMP: begin
                pc_we  = 1'b1;
                pc_d   = {pc[31:28], ir[25:0], 2'b00};
                retire = 1'b1;
                nxt    = FETCH;
            end
            ADDIEX: nxt = ADDIWB;
            ADDIWB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
                nxt    = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= FETCH;
            pc      <= RESET_PC;
            ir      <= 32'h0;
            mdr     <= 32'h0;
            a       <= 32'h0;
            b       <= 32'h0;
            alu_out <= 32'h0;
        end else begin
            cur <= nxt;
            if (pc_we)
                pc <= pc_d;
            if (cur == FETCH)
                ir <= rom[pc[IA+1:2]];
            if (cur == DECODE) begin
                a <= (rs == 5'd0) ? 32'h0 : regs[rs];
                b <= (rt == 5'd0) ? 32'h0 : regs[rt];
            end
            if (cur == DECODE || cur == MEMADR ||
                cur == EXEC || cur == ADDIEX)
                alu_out <= alu_y;
            if (cur == MEMRD)
                mdr <= dmem[alu_out[DA+1:2]];
        end
    end

    // Architectural writes are dropped while reset is high
    always_ff @(posedge clk) begin
        if (!reset && rf_we && rf_dst != 5'd0)
            regs[rf_dst] <= rf_wd;
        if (!reset && dm_we)
            dmem[alu_out[DA+1:2]] <= b;
    end

`ifdef MIPS_MULTI_PERF_EN
    logic [31:0] cyc_q, ins_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 32'h0;
            ins_q <= 32'h0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (retire)
                ins_q <= ins_q + 32'd1;
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = 32'h0;
    assign instr_count = 32'h0;
`endif

endmodule

// File: doc/mips_multi.md
# mips_multi

Multi-cycle MIPS processor: next generation of the single-cycle core, sharing one ALU and adder path across several cycles per instruction under a registered control FSM. It executes the same subset as the single-cycle core (R-type add/sub/and/or/slt, lw, sw, beq, bne, j) plus addi. Instruction memory is a read-only instruction ROM; data memory is a synchronous-write data RAM; the register file is the existing 32x32 two-read/one-write file. It sits at the top of the lab processor hierarchy, replacing the single-cycle top for CPI experiments.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_WORDS, 64, instruction ROM depth in words; fetch index is pc[log2(IMEM_WORDS)+1:2]
- DMEM_WORDS, 64, data RAM depth in words; address index is alu_out[log2(DMEM_WORDS)+1:2]
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- pc  output  32  current program counter
- state  output  4  current FSM state encoding
- retire  output  1  one-cycle pulse in the final cycle of each completed instruction
- cycle_count  output  32  cycles since reset (see Configuration)
- instr_count  output  32  retired instructions since reset (see Configuration)

## Operation
- Internal registers: PC, IR, MDR, A, B, ALUOut, all 32-bit; updated only in states listed.
- FSM states (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- FETCH: IR <= imem[PC]; PC <= PC+4. -> DECODE.
- DECODE: A <= reg[rs]; B <= reg[rt]; ALUOut <= PC + (sext(imm)<<2). Next by opcode: 0x23/0x2B -> MEMADR; 0x00 -> EXEC; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX; any other -> FETCH with retire=1 (nop, no state change).
- MEMADR: ALUOut <= A + sext(imm). lw -> MEMRD, sw -> MEMWR.
- MEMRD: MDR <= dmem[ALUOut]. -> MEMWB. MEMWB: reg[rt] <= MDR; retire. -> FETCH.
- MEMWR: dmem[ALUOut] <= B; retire. -> FETCH.
- EXEC: ALUOut <= A op B, op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt). -> RWB. RWB: reg[rd] <= ALUOut; retire. -> FETCH.
- BRANCH: compute A-B; beq taken if zero, bne taken if nonzero; taken -> PC <= ALUOut; retire. -> FETCH.
- JUMP: PC <= {PC[31:28], IR[25:0], 2'b00}; retire. -> FETCH.
- ADDIEX: ALUOut <= A + sext(imm). ADDIWB: reg[rt] <= ALUOut; retire. -> FETCH.
- Writes with destination register 0 are suppressed; reads of $0 return 0.
- Arithmetic is 32-bit modulo; no overflow exceptions. Unrecognised funct in EXEC produces ALUOut = 0 and still writes rd.
- PC wraps modulo 2^32; fetch index wraps modulo IMEM_WORDS.

## Timing
- Reset: PC=RESET_PC, state=FETCH, IR/MDR/A/B/ALUOut=0, retire=0, counters=0. Reset asserted mid-instruction aborts it: no register-file or memory write occurs in a cycle with reset high.
- First FETCH is the first rising edge after reset deasserts.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, unknown opcode 2.
- retire is combinational from state/opcode, high exactly one cycle per instruction, in the cycle whose edge performs the final write.
- Register file write and data RAM write occur on the clock edge ending the writeback/MEMWR cycle; a following instruction's DECODE sees the new value (no forwarding needed).
- Branch target uses PC+4 (already updated in FETCH).

## Configuration
- MIPS_MULTI_PERF_EN defined: cycle_count increments every non-reset cycle; instr_count increments on every cycle with retire=1; both wrap at 2^32.
- Not defined: cycle_count and instr_count are tied to 0; no counter flops instantiated.

## Test plan
- Reset held 3 cycles with RESET_PC=0x40 -> pc=0x40, state=0, retire=0; after release next edge pc=0x44, state=1.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> reg[3]=12 after 12 cycles; retire pulses at cycles 4, 8, 12.
- sw $3,8($0); lw $4,8($0) -> dmem word 2 = 12, reg[4]=12; CPI 4 then 5.
- beq $1,$1,+2 from pc 0x10 -> pc=0x1C after 3 cycles; bne $1,$1,+2 -> pc=0x14.
- j 0x100 at pc 0x20 -> pc=0x400; addi $0,$0,9 -> reg[0] stays 0; opcode 0x3F -> 2-cycle nop, retire once.
- With MIPS_MULTI_PERF_EN, 5-instruction program totalling 18 cycles -> cycle_count=18, instr_count=5; reset asserted in MEMWB of lw -> destination register unchanged, counters 0.
